// File: rtl/dso_pkg.sv
// Shared types and constants for the channel dump sequencer and its EEPROM reader.
package dso_pkg;
  localparam int          DEPTH   = 512;
  localparam int          ADDR_W  = 9;
  localparam logic [2:0]  EEP_SS  = 3'b100;
  localparam logic [1:0]  EEP_RD  = 2'b00;
  localparam logic [1:0]  CH_RSVD = 2'b11;

  typedef enum logic [2:0] {
    IDLE, OFF_A, OFF_B, GAIN_A, GAIN_B, RD, RD_LAT, TX
  } dump_state_t;

  typedef enum logic [1:0] {
    EEP_IDLE, EEP_CMD, EEP_DATA
  } eep_state_t;

  // Read command word: opcode, 6-bit calibration address, don't-care data byte.
  function automatic logic [15:0] eep_cmd(input logic [5:0] addr);
    return {EEP_RD, addr, 8'h00};
  endfunction
endpackage

// File: rtl/dump_sequencer_if.sv
// Command, SPI, RAM and UART-response signals seen by the dump sequencer.
interface dump_sequencer_if;
  import dso_pkg::*;
  logic              dump;
  logic [1:0]        dump_ch;
  logic [2:0]        ch1_AFEgain;
  logic [2:0]        ch2_AFEgain;
  logic [2:0]        ch3_AFEgain;
  logic [ADDR_W-1:0] trig_addr;
  logic              SPI_done;
  logic              resp_sent;
  logic              wrt_SPI;
  logic [2:0]        ss;
  logic [15:0]       SPI_data;
  logic              flopOffset;
  logic              flopGain;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_en;
  logic              send_resp;
  logic              dump_busy;
  logic              dump_err;

  modport master (
    input  dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain, trig_addr,
           SPI_done, resp_sent,
    output wrt_SPI, ss, SPI_data, flopOffset, flopGain, ram_addr, ram_en,
           send_resp, dump_busy, dump_err
  );

  modport slave (
    output dump, dump_ch, ch1_AFEgain, ch2_AFEgain, ch3_AFEgain, trig_addr,
           SPI_done, resp_sent,
    input  wrt_SPI, ss, SPI_data, flopOffset, flopGain, ram_addr, ram_en,
           send_resp, dump_busy, dump_err
  );
endinterface

// File: rtl/eep_cal_read.sv
// Two-transaction calibration EEPROM read: address word, then a dummy word whose
// completion marks EEP_data valid.
module eep_cal_read
  import dso_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  addr,
  input  logic        SPI_done,
  output logic        wrt_SPI,
  output logic [15:0] SPI_data,
  output logic        data_vld
);
  eep_state_t  st_q, st_d;
  logic        wrt_q, wrt_d;
  logic [15:0] data_q, data_d;

  always_comb begin
    st_d     = st_q;
    wrt_d    = 1'b0;
    data_d   = data_q;
    data_vld = 1'b0;
    case (st_q)
      EEP_CMD: if (SPI_done) begin
        wrt_d  = 1'b1;
        data_d = 16'h0000;
        st_d   = EEP_DATA;
      end
      EEP_DATA: if (SPI_done) begin
        data_vld = 1'b1;
        st_d     = EEP_IDLE;
      end
      default: ;
    endcase
    // A new read may launch in the same cycle the previous one completes.
    if (start && (st_d == EEP_IDLE)) begin
      wrt_d  = 1'b1;
      data_d = eep_cmd(addr);
      st_d   = EEP_CMD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= EEP_IDLE;
      wrt_q  <= 1'b0;
      data_q <= 16'h0000;
    end else begin
      st_q   <= st_d;
      wrt_q  <= wrt_d;
      data_q <= data_d;
    end
  end

  assign wrt_SPI  = wrt_q;
  assign SPI_data = data_q;
endmodule

// File: rtl/dump_sequencer.sv
// Channel dump sequencer: fetches offset/gain calibration from the EEPROM, then
// streams the capture RAM circularly from the oldest sample, one byte per handshake.
module dump_sequencer
  import dso_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  dump_sequencer_if.master bus
);
  localparam int CNT_W = ADDR_W + 1;

  dump_state_t       state_q, state_d;
  logic [1:0]        ch_q, ch_d;
  logic [2:0]        gain_q, gain_d;
  logic [ADDR_W-1:0] trig_q, trig_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ram_en_q, ram_en_d;
  logic              send_resp_q, send_resp_d;
  logic              dump_busy_q, dump_busy_d;
  logic              dump_err_q, dump_err_d;
  logic [2:0]        ss_q, ss_d;
  logic [2:0]        sel_gain;
  logic              eep_start, eep_vld, eep_wrt;
  logic [5:0]        eep_addr;
  logic [15:0]       eep_data;
  logic              flop_off, flop_gain;

  always_comb begin
    case (bus.dump_ch)
      2'b00:   sel_gain = bus.ch1_AFEgain;
      2'b01:   sel_gain = bus.ch2_AFEgain;
      default: sel_gain = bus.ch3_AFEgain;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    gain_d     = gain_q;
    trig_d     = trig_q;
    cnt_d      = cnt_q;
    dump_err_d = 1'b0;
    eep_start  = 1'b0;
    eep_addr   = {ch_q, gain_q, 1'b1};
    flop_off   = 1'b0;
    flop_gain  = 1'b0;
    case (state_q)
      IDLE: if (bus.dump) begin
        if (bus.dump_ch == CH_RSVD) begin
          dump_err_d = 1'b1;
        end else begin
          ch_d      = bus.dump_ch;
          gain_d    = sel_gain;
          trig_d    = bus.trig_addr;
          eep_start = 1'b1;
          eep_addr  = {bus.dump_ch, sel_gain, 1'b0};
          state_d   = OFF_A;
        end
      end
      OFF_A:  if (bus.SPI_done) state_d = OFF_B;
      OFF_B: if (eep_vld) begin
        flop_off  = 1'b1;
        eep_start = 1'b1;
        state_d   = GAIN_A;
      end
      GAIN_A: if (bus.SPI_done) state_d = GAIN_B;
      GAIN_B: if (eep_vld) begin
        flop_gain = 1'b1;
        cnt_d     = '0;
        state_d   = RD;
      end
      RD:     state_d = RD_LAT;
      RD_LAT: state_d = TX;
      TX: if (bus.resp_sent) begin
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = RD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ram_en_d    = (state_d == RD);
    ram_addr_d  = ram_en_d ? trig_d + cnt_d[ADDR_W-1:0] : ram_addr_q;
    send_resp_d = (state_q == RD_LAT);
    dump_busy_d = (state_d != IDLE);
    ss_d        = (state_d inside {OFF_A, OFF_B, GAIN_A, GAIN_B}) ? EEP_SS : 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= 2'b00;
      gain_q      <= 3'b000;
      trig_q      <= '0;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      ram_en_q    <= 1'b0;
      send_resp_q <= 1'b0;
      dump_busy_q <= 1'b0;
      dump_err_q  <= 1'b0;
      ss_q        <= 3'b000;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      gain_q      <= gain_d;
      trig_q      <= trig_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_en_q    <= ram_en_d;
      send_resp_q <= send_resp_d;
      dump_busy_q <= dump_busy_d;
      dump_err_q  <= dump_err_d;
      ss_q        <= ss_d;
    end
  end

  eep_cal_read u_eep (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (eep_start),
    .addr     (eep_addr),
    .SPI_done (bus.SPI_done),
    .wrt_SPI  (eep_wrt),
    .SPI_data (eep_data),
    .data_vld (eep_vld)
  );

  // Calibration strobes coincide with the final SPI_done, while EEP_data is valid.
  assign bus.flopOffset = flop_off;
  assign bus.flopGain   = flop_gain;
  assign bus.wrt_SPI    = eep_wrt;
  assign bus.SPI_data   = eep_data;
  assign bus.ss         = ss_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_en     = ram_en_q;
  assign bus.send_resp  = send_resp_q;
  assign bus.dump_busy  = dump_busy_q;
  assign bus.dump_err   = dump_err_q;
endmodule
